// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - precise-exception controller between MEM stage and CP0
// Optional interrupt detection is enabled by defining EXC_INT_EN.
module exc_ctrl #(
  parameter logic [31:0] HANDLER_PC = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic        mem_stall_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] mem_badaddr_i,
  input  logic        exc_adel_if_i,
  input  logic        exc_ri_i,
  input  logic        exc_ov_i,
  input  logic        exc_sys_i,
  input  logic        exc_bp_i,
  input  logic        exc_eret_i,
  input  logic        exc_adel_ld_i,
  input  logic        exc_ades_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] cp0_pc_o,
  output logic        cp0_delayslot_o,
  output logic [31:0] cp0_badaddr_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] newpc_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, COMMIT, DRAIN} state_t;

  state_t      state_q;
  logic [31:0] excepttype_q;
  logic [31:0] pc_q;
  logic        delayslot_q;
  logic [31:0] badaddr_q;
  logic        eret_q;
  logic        flush_q;

  logic        int_pending;
  logic        any_exc;
  logic [31:0] code_d;
  logic [31:0] badaddr_d;
  logic        eret_d;

`ifdef EXC_INT_EN
  logic unused_status;
  assign unused_status = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};
  assign int_pending = status_i[0] && !status_i[1] && ((cause_i[15:8] & status_i[15:8]) != 8'h00);
`else
  logic unused_status;
  assign unused_status = ^{status_i, cause_i};
  assign int_pending = 1'b0;
`endif

  assign any_exc = int_pending | exc_adel_if_i | exc_ri_i | exc_ov_i | exc_sys_i |
                   exc_bp_i | exc_eret_i | exc_adel_ld_i | exc_ades_i;

  // Fixed priority: the interrupt outranks every synchronous cause.
  always_comb begin
    code_d    = 32'h0;
    badaddr_d = 32'h0;
    eret_d    = 1'b0;
    if (int_pending) begin
      code_d = 32'h1;
    end else if (exc_adel_if_i) begin
      code_d    = 32'h4;
      badaddr_d = mem_pc_i;
    end else if (exc_ri_i) begin
      code_d = 32'hA;
    end else if (exc_ov_i) begin
      code_d = 32'hC;
    end else if (exc_sys_i) begin
      code_d = 32'h8;
    end else if (exc_bp_i) begin
      code_d = 32'h9;
    end else if (exc_eret_i) begin
      code_d = 32'hE;
      eret_d = 1'b1;
    end else if (exc_adel_ld_i) begin
      code_d    = 32'h4;
      badaddr_d = mem_badaddr_i;
    end else if (exc_ades_i) begin
      code_d    = 32'h5;
      badaddr_d = mem_badaddr_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      excepttype_q <= 32'h0;
      pc_q         <= 32'h0;
      delayslot_q  <= 1'b0;
      badaddr_q    <= 32'h0;
      eret_q       <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_valid_i && !mem_stall_i && any_exc) begin
            state_q      <= COMMIT;
            excepttype_q <= code_d;
            pc_q         <= mem_pc_i;
            delayslot_q  <= mem_in_delayslot_i;
            badaddr_q    <= badaddr_d;
            eret_q       <= eret_d;
            flush_q      <= 1'b1;
          end
        end
        COMMIT: begin
          state_q      <= DRAIN;
          excepttype_q <= 32'h0;
          pc_q         <= 32'h0;
          delayslot_q  <= 1'b0;
          badaddr_q    <= 32'h0;
          eret_q       <= 1'b0;
          flush_q      <= 1'b0;
        end
        DRAIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign excepttype_o    = excepttype_q;
  assign cp0_pc_o        = pc_q;
  assign cp0_delayslot_o = delayslot_q;
  assign cp0_badaddr_o   = badaddr_q;
  assign flush_o         = flush_q;
  assign redirect_o      = flush_q;
  // EPC is taken live so a CP0 write landing just before the commit is honoured.
  assign newpc_o         = !flush_q ? 32'h0 : (eret_q ? epc_i : HANDLER_PC);
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - randomized self-checking bench for exc_ctrl
module tb_exc_ctrl;

  localparam logic [31:0] HPC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid_i = 1'b0, mem_stall_i = 1'b0, mem_in_delayslot_i = 1'b0;
  logic [31:0] mem_pc_i = '0, mem_badaddr_i = '0;
  logic        exc_adel_if_i = 0, exc_ri_i = 0, exc_ov_i = 0, exc_sys_i = 0;
  logic        exc_bp_i = 0, exc_eret_i = 0, exc_adel_ld_i = 0, exc_ades_i = 0;
  logic [31:0] status_i = '0, cause_i = '0, epc_i = '0;
  logic [31:0] excepttype_o, cp0_pc_o, cp0_badaddr_o, newpc_o;
  logic        cp0_delayslot_o, flush_o, redirect_o, busy_o;

  int checks = 0;
  int failures = 0;

  exc_ctrl #(.HANDLER_PC(HPC)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .mem_stall_i(mem_stall_i), .mem_pc_i(mem_pc_i),
    .mem_in_delayslot_i(mem_in_delayslot_i), .mem_badaddr_i(mem_badaddr_i),
    .exc_adel_if_i(exc_adel_if_i), .exc_ri_i(exc_ri_i), .exc_ov_i(exc_ov_i),
    .exc_sys_i(exc_sys_i), .exc_bp_i(exc_bp_i), .exc_eret_i(exc_eret_i),
    .exc_adel_ld_i(exc_adel_ld_i), .exc_ades_i(exc_ades_i),
    .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
    .excepttype_o(excepttype_o), .cp0_pc_o(cp0_pc_o), .cp0_delayslot_o(cp0_delayslot_o),
    .cp0_badaddr_o(cp0_badaddr_o), .flush_o(flush_o), .redirect_o(redirect_o),
    .newpc_o(newpc_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: a sample index, the sample at which a commit is visible,
  // and the first sample whose inputs may be accepted again.
  int          s = 0;
  int          commit_at = -100;
  int          free_at = 0;
  logic [31:0] m_code, m_pc, m_bad;
  logic        m_ds, m_eret;

  function automatic bit m_int();
`ifdef EXC_INT_EN
    return status_i[0] && !status_i[1] && ((cause_i[15:8] & status_i[15:8]) != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_accept();
    bit          fl [9];
    logic [31:0] codes [9];
    bit          found;
    fl = '{m_int(), exc_adel_if_i, exc_ri_i, exc_ov_i, exc_sys_i, exc_bp_i,
           exc_eret_i, exc_adel_ld_i, exc_ades_i};
    codes = '{32'h1, 32'h4, 32'hA, 32'hC, 32'h8, 32'h9, 32'hE, 32'h4, 32'h5};
    found = 0;
    for (int i = 0; i < 9; i++) begin
      if (fl[i] && !found) begin
        found  = 1;
        m_code = codes[i];
        m_eret = (i == 6);
        m_bad  = (i == 1) ? mem_pc_i : ((i == 7 || i == 8) ? mem_badaddr_i : 32'h0);
      end
    end
    if (found && mem_valid_i && !mem_stall_i && s >= free_at) begin
      m_pc      = mem_pc_i;
      m_ds      = mem_in_delayslot_i;
      commit_at = s;
      free_at   = s + 3;
    end
  endtask

  // Inputs set by the caller are captured at the coming posedge; outputs are
  // compared at the following negedge.
  task automatic step();
    bit c;
    model_accept();
    @(negedge clk);
    c = (s == commit_at);
    check("excepttype", excepttype_o, c ? m_code : 32'h0);
    check("cp0_pc", cp0_pc_o, c ? m_pc : 32'h0);
    check("delayslot", {31'h0, cp0_delayslot_o}, {31'h0, c & m_ds});
    check("badaddr", cp0_badaddr_o, c ? m_bad : 32'h0);
    check("flush", {31'h0, flush_o}, {31'h0, c});
    check("redirect", {31'h0, redirect_o}, {31'h0, c});
    check("newpc", newpc_o, c ? (m_eret ? epc_i : HPC) : 32'h0);
    check("busy", {31'h0, busy_o}, {31'h0, (s == commit_at) || (s == commit_at + 1)});
    s++;
  endtask

  task automatic clear_inputs();
    {exc_adel_if_i, exc_ri_i, exc_ov_i, exc_sys_i, exc_bp_i, exc_eret_i, exc_adel_ld_i, exc_ades_i} = '0;
    mem_valid_i = 0; mem_stall_i = 0; mem_in_delayslot_i = 0;
    status_i = 0; cause_i = 0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2;
    check("reset_flush", {31'h0, flush_o}, 32'h0);
    check("reset_busy", {31'h0, busy_o}, 32'h0);
    check("reset_newpc", newpc_o, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 0;

    // ADES alone
    mem_valid_i = 1; exc_ades_i = 1; mem_pc_i = 32'h8000_0100; mem_badaddr_i = 32'h8000_0203;
    step();
    check("ades_code", excepttype_o, 32'h5);
    check("ades_pc", cp0_pc_o, 32'h8000_0100);
    check("ades_bad", cp0_badaddr_o, 32'h8000_0203);
    check("ades_newpc", newpc_o, 32'hBFC0_0380);
    idle(3);

    // Priority RI > OV > ADEL load
    mem_valid_i = 1; exc_ri_i = 1; exc_ov_i = 1; exc_adel_ld_i = 1;
    step();
    check("prio_code", excepttype_o, 32'hA);
    check("prio_bad", cp0_badaddr_o, 32'h0);
    idle(3);

    // Interrupt, masked by EXL, and with eret in the same cycle
    mem_valid_i = 1; status_i = 32'h401; cause_i = 32'h400;
    step();
`ifdef EXC_INT_EN
    check("int_code", excepttype_o, 32'h1);
`else
    check("int_off", {31'h0, flush_o}, 32'h0);
`endif
    idle(3);
    mem_valid_i = 1; status_i = 32'h403; cause_i = 32'h400;
    step();
    check("int_exl", {31'h0, flush_o}, 32'h0);
    idle(2);
    mem_valid_i = 1; status_i = 32'h401; cause_i = 32'h400; exc_eret_i = 1;
    mem_pc_i = 32'h8000_0077; epc_i = 32'h8000_0040;
    step();
    check("int_eret_pc", cp0_pc_o, 32'h8000_0077);
    idle(3);

    // ERET
    mem_valid_i = 1; exc_eret_i = 1; epc_i = 32'h8000_0040;
    step();
    check("eret_code", excepttype_o, 32'hE);
    check("eret_newpc", newpc_o, 32'h8000_0040);
    idle(1);
    check("eret_once", {31'h0, redirect_o}, 32'h0);
    idle(2);

    // Stall then commit, BREAK during COMMIT/DRAIN discarded
    mem_valid_i = 1; exc_sys_i = 1; mem_stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", {31'h0, flush_o}, 32'h0);
    end
    mem_stall_i = 0;
    step();
    check("sys_code", excepttype_o, 32'h8);
    exc_sys_i = 0; exc_bp_i = 1;
    step();
    step();
    clear_inputs();
    step();
    check("drain_bp", {31'h0, flush_o}, 32'h0);
    idle(2);

    // Asynchronous reset in the COMMIT cycle
    mem_valid_i = 1; exc_ov_i = 1;
    step();
    check("pre_rst_flush", {31'h0, flush_o}, 32'h1);
    clear_inputs();
    #2 rst = 1;
    #1;
    check("rst_flush", {31'h0, flush_o}, 32'h0);
    check("rst_code", excepttype_o, 32'h0);
    check("rst_newpc", newpc_o, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    @(negedge clk);
    rst = 0;
    s++;
    commit_at = -100;
    free_at = s;
    idle(2);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      mem_valid_i = ($urandom_range(0, 9) < 8);
      mem_stall_i = ($urandom_range(0, 9) < 2);
      mem_in_delayslot_i = $urandom_range(0, 1);
      mem_pc_i = $urandom; mem_badaddr_i = $urandom; epc_i = $urandom;
      exc_adel_if_i = ($urandom_range(0, 15) == 0);
      exc_ri_i      = ($urandom_range(0, 15) == 0);
      exc_ov_i      = ($urandom_range(0, 15) == 0);
      exc_sys_i     = ($urandom_range(0, 15) == 0);
      exc_bp_i      = ($urandom_range(0, 15) == 0);
      exc_eret_i    = ($urandom_range(0, 15) == 0);
      exc_adel_ld_i = ($urandom_range(0, 15) == 0);
      exc_ades_i    = ($urandom_range(0, 15) == 0);
      status_i = {16'h0, 8'($urandom), 6'h0, 1'($urandom_range(0, 3) == 0), 1'($urandom)};
      cause_i  = {16'h0, 8'($urandom_range(0, 3) == 0 ? $urandom : 0), 8'h0};
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
